image_sample_sequencer: RTL and testbench

Read-side controller for the single-port image RAM holding the MNIST training set, one sample per word. On `start` it walks every address for a programmed number of epochs and streams each word to the learner over a valid/ready handshake. A 2-entry output buffer with credit-based read issue absorbs the RAM's one-cycle read latency, so downstream stalls lose no sample and `ready` held high gives one sample per cycle. The block sits between the image RAM and the training datapath and owns the RAM port during a run.

---
 rtl/image_seq_pkg.sv | 13 +
 rtl/sample_skid_fifo.sv | 79 +++++++
 rtl/image_sample_sequencer.sv | 148 ++++++++++++++
 tb/tb_image_sample_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/image_seq_pkg.sv
// Shared types and constants for the image sample sequencer and its output buffer.
package image_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    localparam int LABEL_BIT  = 0;
    localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/sample_skid_fifo.sv
// Two-entry FIFO with a `last` sideband; exposes its occupancy so the
// sequencer can issue RAM reads only when a landing slot is guaranteed.
module sample_skid_fifo #(
    parameter int DATA_WIDTH = 785
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  push_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] entry_data [2];
    logic [1:0]            entry_last;
    logic                  wr_ptr_reg;
    logic                  rd_ptr_reg;
    logic [1:0]            count_reg;
    logic                  pop;
    logic                  write;

    assign out_valid = (count_reg != 2'd0);
    assign pop       = out_valid && out_ready;
    assign write     = push && !flush;

    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        logic [DATA_WIDTH-1:0] data_reg;
        logic                  last_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_reg <= '0;
                last_reg <= 1'b0;
            end else if (write && (wr_ptr_reg == 1'(gi))) begin
                data_reg <= push_data;
                last_reg <= push_last;
            end
        end

        assign entry_data[gi] = data_reg;
        assign entry_last[gi] = last_reg;
    end

    // A push into a full buffer is only legal alongside a pop: it overwrites
    // the head slot exactly as that head leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else if (flush) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (write) begin
                wr_ptr_reg <= !wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= !rd_ptr_reg;
            end
            case ({write, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign out_data = entry_data[rd_ptr_reg];
    assign out_last = entry_last[rd_ptr_reg];
    assign count    = count_reg;

endmodule

// File: rtl/image_sample_sequencer.sv
// Streams every word of the image RAM to the learner for a programmed number
// of epochs, with credit-gated reads so downstream stalls never drop a sample.
module image_sample_sequencer
    import image_seq_pkg::*;
#(
    parameter int ADDR_WIDTH  = 14,
    parameter int DATA_WIDTH  = 785,
    parameter int NUM_SAMPLES = 16384,
    parameter int EPOCH_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [EPOCH_WIDTH-1:0] num_epochs,
    output logic                   busy,
    output logic                   done,
    output logic [EPOCH_WIDTH-1:0] epoch,
    output logic                   ram_en,
    output logic                   ram_we,
    output logic [ADDR_WIDTH-1:0]  ram_addr,
    input  logic [DATA_WIDTH-1:0]  ram_dout,
    output logic                   smp_valid,
    input  logic                   smp_ready,
    output logic [DATA_WIDTH-1:0]  smp_data,
    output logic                   smp_last
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_SAMPLES - 1);

    state_t                 state_reg, state_next;
    logic [ADDR_WIDTH-1:0]  addr_reg, addr_next;
    logic [EPOCH_WIDTH-1:0] epoch_reg, epoch_next;
    logic [EPOCH_WIDTH-1:0] epochs_reg, epochs_next;
    logic                   pending_reg, pending_next;
    logic                   pending_last_reg, pending_last_next;
    logic                   done_reg, done_next;
    logic                   issue;
    logic                   flush;
    logic                   pop;
    logic [1:0]             fifo_count;
    logic [2:0]             used;

    assign pop = smp_valid && smp_ready;
    // Slots still spoken for at the end of this cycle: buffered words not
    // leaving now, plus the read whose data is on ram_dout now.
    assign used = {1'b0, fifo_count} + {2'b00, pending_reg} - {2'b00, pop};

    always_comb begin
        state_next        = state_reg;
        addr_next         = addr_reg;
        epoch_next        = epoch_reg;
        epochs_next       = epochs_reg;
        done_next         = 1'b0;
        issue             = 1'b0;
        flush             = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start && !abort) begin
                    if (num_epochs == '0) begin
                        done_next = 1'b1;
                    end else begin
                        state_next  = RUN;
                        addr_next   = '0;
                        epoch_next  = '0;
                        epochs_next = num_epochs;
                    end
                end
            end
            RUN: begin
                issue = !abort && (used < 3'(FIFO_DEPTH));
                if (issue) begin
                    if (addr_reg == LAST_ADDR) begin
                        addr_next = '0;
                        if (epoch_reg == epochs_reg - EPOCH_WIDTH'(1)) begin
                            state_next = DRAIN;
                        end else begin
                            epoch_next = epoch_reg + EPOCH_WIDTH'(1);
                        end
                    end else begin
                        addr_next = addr_reg + ADDR_WIDTH'(1);
                    end
                end
            end
            DRAIN: begin
                if (used == 3'd0) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (abort) begin
            state_next = IDLE;
            flush      = 1'b1;
            done_next  = 1'b0;
        end

        pending_next      = issue;
        pending_last_next = issue && (addr_reg == LAST_ADDR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            addr_reg         <= '0;
            epoch_reg        <= '0;
            epochs_reg       <= '0;
            pending_reg      <= 1'b0;
            pending_last_reg <= 1'b0;
            done_reg         <= 1'b0;
        end else begin
            state_reg        <= state_next;
            addr_reg         <= addr_next;
            epoch_reg        <= epoch_next;
            epochs_reg       <= epochs_next;
            pending_reg      <= pending_next;
            pending_last_reg <= pending_last_next;
            done_reg         <= done_next;
        end
    end

    sample_skid_fifo #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (pending_reg),
        .push_data (ram_dout),
        .push_last (pending_last_reg),
        .out_valid (smp_valid),
        .out_ready (smp_ready),
        .out_data  (smp_data),
        .out_last  (smp_last),
        .count     (fifo_count)
    );

    assign busy     = (state_reg != IDLE);
    assign done     = done_reg;
    assign epoch    = epoch_reg;
    assign ram_en   = issue;
    assign ram_we   = 1'b0;
    assign ram_addr = addr_reg;

endmodule

// File: tb/tb_image_sample_sequencer.sv
// Directed bench for image_sample_sequencer: a reference stream of expected
// samples per run, checked against every read issue and every transfer.
module tb_image_sample_sequencer;

    localparam int AW = 3;
    localparam int DW = 17;
    localparam int NS = 4;
    localparam int EW = 8;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic          start      = 1'b0;
    logic          abort      = 1'b0;
    logic          smp_ready  = 1'b0;
    logic [EW-1:0] num_epochs = '0;
    logic          busy, done, ram_en, ram_we, smp_valid, smp_last;
    logic [EW-1:0] epoch;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_dout = '0;
    logic [DW-1:0] smp_data;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } smp_t;

    smp_t    exp_q[$];
    int      checks = 0, errors = 0;
    int      cyc = 0;
    int      issued = 0, xfer = 0, total = 0, done_cnt = 0;
    int      done_cyc = -1, last_xfer_cyc = -1, first_iss_cyc = -1, last_iss_cyc = -1;
    int      t0;
    logic [31:0] last_mask = '0;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    logic [3:0]    pat = 4'b1001;

    image_sample_sequencer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SAMPLES(NS), .EPOCH_WIDTH(EW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .num_epochs(num_epochs), .busy(busy), .done(done), .epoch(epoch),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_dout(ram_dout),
        .smp_valid(smp_valid), .smp_ready(smp_ready), .smp_data(smp_data),
        .smp_last(smp_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_en) ram_dout <= mem[ram_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        issued = 0; xfer = 0; total = 0; done_cnt = 0;
        done_cyc = -1; last_xfer_cyc = -1; first_iss_cyc = -1; last_iss_cyc = -1;
        last_mask = '0;
    endtask

    // One run of ne epochs must deliver every RAM word in address order, ne times.
    task automatic arm(input int ne);
        smp_t s;
        total += ne * NS;
        for (int e = 0; e < ne; e++) begin
            for (int a = 0; a < NS; a++) begin
                s.data = mem[a];
                s.last = (a == NS - 1);
                exp_q.push_back(s);
            end
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic observe();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int maxc, input bit bp);
        int n;
        n = 0;
        while (done_cnt == 0 && n < maxc) begin
            next_cycle();
            smp_ready = bp ? pat[cyc % 4] : 1'b1;
            observe();
            n++;
        end
        check("done_seen", done_cnt, 1);
    endtask

    always @(negedge clk) begin
        smp_t e;
        if (rst_n) begin
            check("ram_we", ram_we, 0);
            if (ram_en) begin
                check("ram_addr", ram_addr, issued % NS);
                check("epoch", epoch, issued / NS);
                check("read_budget", issued < total, 1);
                if (first_iss_cyc < 0) first_iss_cyc = cyc;
                last_iss_cyc = cyc;
                issued++;
            end
            if (smp_valid && smp_ready) begin
                check("xfer_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("smp_data", smp_data, e.data);
                    check("smp_last", smp_last, e.last);
                end
                if (smp_last && xfer < 32) last_mask[xfer] = 1'b1;
                $display("xfer %0d cycle %0d data=%h last=%b", xfer, cyc, smp_data, smp_last);
                xfer++;
                last_xfer_cyc = cyc;
            end
            if (ram_en || (smp_valid && smp_ready)) check("outstanding_le_2", (issued - xfer) <= 2, 1);
            if (stall_prev) begin
                check("hold_valid", smp_valid, 1);
                check("hold_data", smp_data, prev_data);
                check("hold_last", smp_last, prev_last);
            end
            stall_prev = smp_valid && !smp_ready && !abort;
            prev_data  = smp_data;
            prev_last  = smp_last;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_epoch"}, epoch, 0);
        check({tag, "_ram_en"}, ram_en, 0);
        check({tag, "_ram_addr"}, ram_addr, 0);
        check({tag, "_smp_valid"}, smp_valid, 0);
        check({tag, "_smp_last"}, smp_last, 0);
        check({tag, "_smp_data"}, smp_data, 0);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'((i + 1) * 12097);

        // Reset state
        observe();
        check_reset_outputs("rst");
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // Two epochs, ready held high: back-to-back reads and transfers
        clear_model();
        smp_ready = 1'b1; start = 1'b1; num_epochs = 8'd2; arm(2); t0 = cyc;
        observe();
        check("t0_busy", busy, 0);
        next_cycle(); start = 1'b0;
        observe();
        check("t1_busy", busy, 1);
        check("t1_ram_en", ram_en, 1);
        check("t1_ram_addr", ram_addr, 0);
        next_cycle(); observe();
        check("t2_valid", smp_valid, 0);
        next_cycle(); observe();
        check("t3_valid", smp_valid, 1);
        check("t3_data", smp_data, 17'h02F41);
        wait_done(40, 1'b0);
        check("run1_xfers", xfer, 8);
        check("run1_reads", issued, 8);
        check("run1_first_read", first_iss_cyc - t0, 1);
        check("run1_read_span", last_iss_cyc - first_iss_cyc, 7);
        check("run1_last_mask", last_mask, 32'h88);
        check("run1_done_cycle", done_cyc - t0, 11);
        check("run1_done_after_last", done_cyc - last_xfer_cyc, 1);
        check("run1_busy_at_done", busy, 0);
        next_cycle(); observe();
        check("run1_done_pulse", done, 0);

        // Backpressure: ready follows 1,0,0,1
        clear_model();
        start = 1'b1; num_epochs = 8'd2; arm(2);
        next_cycle(); start = 1'b0;
        wait_done(100, 1'b1);
        check("bp_xfers", xfer, 8);
        check("bp_queue_empty", exp_q.size(), 0);
        check("bp_done_after_last", done_cyc - last_xfer_cyc, 1);

        // Zero epochs: done next cycle, no reads, never busy
        next_cycle(); smp_ready = 1'b1;
        clear_model();
        start = 1'b1; num_epochs = 8'd0;
        observe();
        check("zero_busy_t0", busy, 0);
        next_cycle(); start = 1'b0;
        observe();
        check("zero_done", done, 1);
        check("zero_busy_t1", busy, 0);
        for (int i = 0; i < 4; i++) begin next_cycle(); observe(); end
        check("zero_reads", issued, 0);
        check("zero_done_count", done_cnt, 1);

        // Abort with the buffer full, then restart
        next_cycle();
        clear_model();
        smp_ready = 1'b0; start = 1'b1; num_epochs = 8'd3; arm(3);
        next_cycle(); start = 1'b0;
        for (int i = 0; i < 7; i++) begin next_cycle(); observe(); end
        check("full_valid", smp_valid, 1);
        check("full_ram_en", ram_en, 0);
        check("full_reads", issued, 2);
        check("full_data", smp_data, 17'h02F41);
        next_cycle(); abort = 1'b1;
        observe();
        check("abort_ram_en", ram_en, 0);
        next_cycle(); abort = 1'b0; clear_model();
        observe();
        check("abort_valid", smp_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        for (int i = 0; i < 3; i++) begin next_cycle(); observe(); end
        check("abort_no_done", done_cnt, 0);
        check("abort_no_reads", issued, 0);
        next_cycle();
        smp_ready = 1'b1; start = 1'b1; num_epochs = 8'd1; arm(1);
        next_cycle(); start = 1'b0;
        observe();
        check("restart_addr", ram_addr, 0);
        check("restart_epoch", epoch, 0);
        check("restart_ram_en", ram_en, 1);
        wait_done(30, 1'b0);
        check("restart_xfers", xfer, 4);

        // Reset asserted mid-run
        next_cycle();
        clear_model();
        start = 1'b1; num_epochs = 8'd3; arm(3);
        next_cycle(); start = 1'b0;
        for (int i = 0; i < 5; i++) next_cycle();
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        clear_model();
        next_cycle(); next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin next_cycle(); observe(); end
        check("postrst_busy", busy, 0);
        check("postrst_reads", issued, 0);
        check("postrst_done", done_cnt, 0);

        // Start pulsed while busy is ignored
        next_cycle();
        clear_model();
        start = 1'b1; num_epochs = 8'd2; arm(2);
        next_cycle(); start = 1'b0;
        for (int i = 0; i < 3; i++) next_cycle();
        start = 1'b1; num_epochs = 8'd5;
        next_cycle(); start = 1'b0;
        wait_done(40, 1'b0);
        check("busy_start_reads", issued, 8);
        check("busy_start_xfers", xfer, 8);
        for (int i = 0; i < 3; i++) begin next_cycle(); observe(); end
        check("busy_start_done_count", done_cnt, 1);

        // Abort beats a simultaneous start
        next_cycle();
        clear_model();
        start = 1'b1; abort = 1'b1; num_epochs = 8'd2;
        next_cycle(); start = 1'b0; abort = 1'b0;
        observe();
        check("abort_start_busy", busy, 0);
        next_cycle(); observe();
        check("abort_start_done", done_cnt, 0);
        check("abort_start_reads", issued, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
